wb_rr_arbiter: RTL and testbench
================================

# wb_rr_arbiter

Three-master round-robin Wishbone arbiter with a bus-timeout watchdog. It shares one Wishbone slave port, such as the conbus master side or a single peripheral, between up to three requesters: LM32 instruction, LM32 data and a future DMA engine. It grants ownership per Wishbone cycle (cyc-framed), muxes the granted master onto the slave port, and aborts any transfer that stalls for more than `timeout_cycles` clock cycles.

## Interface
- `adr_w`, 32: address width of every adr port.
- `timeout_cycles`, 255: number of consecutive un-acked strobe cycles before an abort. 0 disables the watchdog. Legal range 0..65535.

Ports:
- `clk`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `mN_adr_i`  input  adr_w  master N address (N = 0..2, same for all per-master lines below).
- `mN_dat_i`  input  32  master N write data.
- `mN_sel_i`  input  4  master N byte select.
- `mN_we_i`  input  1  master N write enable.
- `mN_cyc_i`  input  1  master N cycle request.
- `mN_stb_i`  input  1  master N strobe.
- `mN_dat_o`  output  32  read data; `s_dat_i` broadcast to all masters.
- `mN_ack_o`  output  1  acknowledge, routed to the granted master only.
- `mN_err_o`  output  1  one-cycle abort pulse to the timed-out master.
- `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_we_o`  output  adr_w/32/4/1  muxed from the granted master.
- `s_cyc_o`, `s_stb_o`  output  1  granted master's cyc/stb, gated by grant.
- `s_dat_i`  input  32  slave read data.
- `s_ack_i`  input  1  slave acknowledge.
- `gnt_o`  output  3  one-hot current grant (status/debug).

## Operation
- Registers:
  - `state` ∈ {IDLE, BUSY}.
  - `owner[1:0]`: granted master.
  - `last[1:0]`: last master granted.
  - `tmo_cnt[15:0]`: watchdog counter.
  - `err_q[2:0]`: registered error pulses.
- Reset values: `state`=IDLE, `owner`=0, `last`=2, `tmo_cnt`=0, `err_q`=0. All outputs: `gnt_o`=0, `s_cyc_o`=0, `s_stb_o`=0, `mN_ack_o`=0, `mN_err_o`=0. Mux outputs follow `owner`=0.
- **IDLE:**
  - If any `mN_cyc_i`=1, pick the first requester scanning `last+1`, `last+2`, `last+3` (mod 3).
  - Register it into `owner` and `last`, then go to BUSY.
  - With no request, stay in IDLE.
- **BUSY:**
  - `s_*` outputs come from master `owner`.
  - `s_cyc_o` = `m[owner]_cyc_i`; `s_stb_o` = `m[owner]_stb_i`.
  - `m[owner]_ack_o` = `s_ack_i`; all other acks are 0.
  - `gnt_o` = one-hot(`owner`).
- **BUSY → IDLE** when either:
  - `m[owner]_cyc_i`=0 is sampled, or
  - the watchdog fires.
- Non-owner requests are ignored until the next IDLE; they are never dropped, only delayed.
- **Watchdog (BUSY, `timeout_cycles`≠0):**
  - `tmo_cnt` increments on every cycle with `s_stb_o`=1 and `s_ack_i`=0.
  - It clears on `s_ack_i`=1 and on entry to IDLE.
  - When `tmo_cnt` = `timeout_cycles`−1 and the current cycle is still un-acked, the edge does three things: sets `err_q[owner]`=1, clears the grant, and enters IDLE.
- `err_q` self-clears after one cycle.
- A master receiving err must drop cyc. If it keeps cyc high, it simply re-enters arbitration.
- In IDLE, `s_cyc_o`/`s_stb_o` = 0 and all acks = 0; a stray `s_ack_i` is discarded.

## Timing
- Grant latency: 1 cycle. `mN_cyc_i` rising in cycle t gives `s_cyc_o`=1 in cycle t+1 (from IDLE).
- Release: a master dropping cyc in cycle t gives `gnt_o`=0 in t+1. The next owner's `s_cyc_o` appears in t+2, so there is exactly one dead cycle between owners.
- Ack path is combinational: `s_ack_i` → `m[owner]_ack_o` in the same cycle, with zero added latency. `s_dat_i` → `mN_dat_o` is also combinational.
- Error: abort edge at the end of cycle t. In t+1, `mN_err_o`=1, `s_cyc_o`=0 and `gnt_o`=0.
- Ack in the same cycle the count would expire: the ack wins. No err is raised, the counter clears and ownership continues.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronously). After release, arbitration restarts with m0 having first priority.
- Owner holding cyc with stb low: no counting and no timeout. A lock-style hold is legal indefinitely.

## Test plan
- **Simultaneous requests:** reset, then all three `mN_cyc_i`/`stb_i`=1, slave acks in 1 cycle, each master drops cyc after one ack → grant order m0, m1, m2, m0; one dead cycle between grants.
- **Mux correctness:** m1 writes adr 0x2000_0004, dat 0xDEADBEEF, sel 0xF while m0 and m2 present garbage → the slave port shows exactly m1's values; `m1_ack_o` pulses and m0/m2 acks stay 0.
- **Fairness:** m0 re-requests immediately after every cycle while m2 requests continuously → m0 and m2 alternate grants; m2 is never starved beyond one m0 cycle.
- **Timeout:** `timeout_cycles`=4, m2 strobes and the slave never acks → after 4 un-acked cycles, `m2_err_o`=1 for exactly one cycle and `s_cyc_o`=0 in that cycle; the next requester is granted one cycle later.
- **Ack at the deadline:** `timeout_cycles`=4, slave acks on the 4th strobe cycle → `m0_ack_o`=1, no err, owner unchanged.
- **Reset mid-burst:** assert `reset` while m1 is granted mid-burst → `s_cyc_o`, `gnt_o` and all acks go to 0 without waiting for `clk`; after deassert with m1 and m0 requesting, m0 is granted first.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: three-master round-robin Wishbone arbiter.
// Ownership is granted per Wishbone cycle (framed by cyc) and the granted
// master is muxed onto a single slave port. A watchdog aborts any transfer
// whose strobe stays un-acked for timeout_cycles consecutive cycles.
module wb_rr_arbiter #(
  parameter int adr_w          = 32,
  parameter int timeout_cycles = 255
) (
  input  logic             clk,
  input  logic             reset,
  // master 0
  input  logic [adr_w-1:0] m0_adr_i,
  input  logic [31:0]      m0_dat_i,
  input  logic [3:0]       m0_sel_i,
  input  logic             m0_we_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  output logic [31:0]      m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  // master 1
  input  logic [adr_w-1:0] m1_adr_i,
  input  logic [31:0]      m1_dat_i,
  input  logic [3:0]       m1_sel_i,
  input  logic             m1_we_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  output logic [31:0]      m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  // master 2
  input  logic [adr_w-1:0] m2_adr_i,
  input  logic [31:0]      m2_dat_i,
  input  logic [3:0]       m2_sel_i,
  input  logic             m2_we_i,
  input  logic             m2_cyc_i,
  input  logic             m2_stb_i,
  output logic [31:0]      m2_dat_o,
  output logic             m2_ack_o,
  output logic             m2_err_o,
  // shared slave port
  output logic [adr_w-1:0] s_adr_o,
  output logic [31:0]      s_dat_o,
  output logic [3:0]       s_sel_o,
  output logic             s_we_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic [31:0]      s_dat_i,
  input  logic             s_ack_i,
  // status
  output logic [2:0]       gnt_o
);

  // A zero timeout disables the watchdog entirely.
  localparam bit          WD_EN    = (timeout_cycles != 0);
  // Count value at which one more un-acked strobe cycle triggers the abort.
  localparam logic [15:0] TMO_LAST = 16'(timeout_cycles - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_reg,   state_next;
  logic [1:0]  owner_reg,   owner_next;
  logic [1:0]  last_reg,    last_next;
  logic [15:0] tmo_cnt_reg, tmo_cnt_next;
  logic [2:0]  err_q_reg,   err_q_next;

  // Per-master request lines gathered into indexable arrays so the mux and
  // the arbitration scan can be written once for all masters.
  logic [adr_w-1:0] adr_vec [3];
  logic [31:0]      dat_vec [3];
  logic [3:0]       sel_vec [3];
  logic [2:0]       we_vec;
  logic [2:0]       cyc_vec;
  logic [2:0]       stb_vec;
  logic [2:0]       ack_vec;

  assign adr_vec[0] = m0_adr_i;
  assign adr_vec[1] = m1_adr_i;
  assign adr_vec[2] = m2_adr_i;
  assign dat_vec[0] = m0_dat_i;
  assign dat_vec[1] = m1_dat_i;
  assign dat_vec[2] = m2_dat_i;
  assign sel_vec[0] = m0_sel_i;
  assign sel_vec[1] = m1_sel_i;
  assign sel_vec[2] = m2_sel_i;
  assign we_vec     = {m2_we_i,  m1_we_i,  m0_we_i};
  assign cyc_vec    = {m2_cyc_i, m1_cyc_i, m0_cyc_i};
  assign stb_vec    = {m2_stb_i, m1_stb_i, m0_stb_i};

  logic busy;
  logic owner_cyc;
  logic owner_stb;
  logic any_req;

  assign busy      = (state_reg == BUSY);
  assign owner_cyc = cyc_vec[owner_reg];
  assign owner_stb = stb_vec[owner_reg];
  assign any_req   = |cyc_vec;

  // Successor of a master index in the 0 -> 1 -> 2 -> 0 rotation.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [1:0] cand3;
  logic [1:0] pick;

  // Round-robin scan starting just after the last granted master; the last
  // master itself is considered only when nobody else is asking.
  always_comb begin
    cand1 = next_idx(last_reg);
    cand2 = next_idx(cand1);
    cand3 = next_idx(cand2);
    pick  = cand3;
    if (cyc_vec[cand1]) begin
      pick = cand1;
    end else if (cyc_vec[cand2]) begin
      pick = cand2;
    end
  end

  // State registers; asynchronous reset puts every output at its idle value
  // immediately and makes m0 the first master in the rotation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      owner_reg   <= 2'd0;
      last_reg    <= 2'd2;
      tmo_cnt_reg <= 16'd0;
      err_q_reg   <= 3'b000;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      last_reg    <= last_next;
      tmo_cnt_reg <= tmo_cnt_next;
      err_q_reg   <= err_q_next;
    end
  end

  // Next-state logic: grant in IDLE, release on cyc drop or watchdog abort.
  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    last_next    = last_reg;
    tmo_cnt_next = tmo_cnt_reg;
    err_q_next   = 3'b000;   // error pulses last exactly one cycle
    unique case (state_reg)
      IDLE: begin
        tmo_cnt_next = 16'd0;
        if (any_req) begin
          owner_next = pick;
          last_next  = pick;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (!owner_cyc) begin
          // Owner closed its cycle; go back to arbitration.
          state_next   = IDLE;
          tmo_cnt_next = 16'd0;
        end else if (s_ack_i) begin
          // Any ack restarts the stall window, even on the deadline cycle.
          tmo_cnt_next = 16'd0;
        end else if (WD_EN && owner_stb) begin
          if (tmo_cnt_reg == TMO_LAST) begin
            err_q_next   = 3'b001 << owner_reg;
            state_next   = IDLE;
            tmo_cnt_next = 16'd0;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + 16'd1;
          end
        end
        // Owner holding cyc with stb low is a legal bus lock: no counting.
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Slave-side mux follows owner even in IDLE; only cyc/stb are gated.
  assign s_adr_o = adr_vec[owner_reg];
  assign s_dat_o = dat_vec[owner_reg];
  assign s_sel_o = sel_vec[owner_reg];
  assign s_we_o  = we_vec[owner_reg];
  assign s_cyc_o = busy & owner_cyc;
  assign s_stb_o = busy & owner_stb;

  // Per-master grant decode and ack routing; a stray ack in IDLE is dropped.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_master
      assign gnt_o[gi]   = busy && (owner_reg == 2'(gi));
      assign ack_vec[gi] = gnt_o[gi] & s_ack_i;
    end
  endgenerate

  assign m0_ack_o = ack_vec[0];
  assign m1_ack_o = ack_vec[1];
  assign m2_ack_o = ack_vec[2];

  assign m0_err_o = err_q_reg[0];
  assign m1_err_o = err_q_reg[1];
  assign m2_err_o = err_q_reg[2];

  // Read data is broadcast; only the acked master will consume it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m2_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Testbench for wb_rr_arbiter: grant-order scoreboard plus directed checks
// of mux routing, watchdog abort, ack-at-deadline and asynchronous reset.
module tb_wb_rr_arbiter;
  localparam int ADR_W = 32;
  localparam int TMO   = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [ADR_W-1:0] adr_drv [3];
  logic [31:0]      dat_drv [3];
  logic [3:0]       sel_drv [3];
  logic [2:0]       we_drv;
  logic [2:0]       cyc_drv;
  logic [2:0]       stb_drv;
  logic [31:0]      s_dat_in;
  logic             ack_auto;
  logic             ack_force;

  wire [ADR_W-1:0] s_adr;
  wire [31:0]      s_dat_out;
  wire [3:0]       s_sel;
  wire             s_we, s_cyc, s_stb;
  wire [31:0]      m0_dat, m1_dat, m2_dat;
  wire             m0_ack, m1_ack, m2_ack;
  wire             m0_err, m1_err, m2_err;
  wire [2:0]       gnt;
  wire [2:0]       ack_vec = {m2_ack, m1_ack, m0_ack};
  wire [2:0]       err_vec = {m2_err, m1_err, m0_err};

  // Slave model: either acks every strobe at once or follows ack_force.
  wire s_ack = ack_auto ? s_stb : ack_force;

  wb_rr_arbiter #(.adr_w(ADR_W), .timeout_cycles(TMO)) dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(adr_drv[0]), .m0_dat_i(dat_drv[0]), .m0_sel_i(sel_drv[0]),
    .m0_we_i(we_drv[0]), .m0_cyc_i(cyc_drv[0]), .m0_stb_i(stb_drv[0]),
    .m0_dat_o(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_adr_i(adr_drv[1]), .m1_dat_i(dat_drv[1]), .m1_sel_i(sel_drv[1]),
    .m1_we_i(we_drv[1]), .m1_cyc_i(cyc_drv[1]), .m1_stb_i(stb_drv[1]),
    .m1_dat_o(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m2_adr_i(adr_drv[2]), .m2_dat_i(dat_drv[2]), .m2_sel_i(sel_drv[2]),
    .m2_we_i(we_drv[2]), .m2_cyc_i(cyc_drv[2]), .m2_stb_i(stb_drv[2]),
    .m2_dat_o(m2_dat), .m2_ack_o(m2_ack), .m2_err_o(m2_err),
    .s_adr_o(s_adr), .s_dat_o(s_dat_out), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_dat_i(s_dat_in), .s_ack_i(s_ack),
    .gnt_o(gnt)
  );

  int checks = 0;
  int errors = 0;
  int exp_gnt_q [$];
  int rem [3];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Grant monitor: every new grant pops the scoreboard and must follow a
  // cycle with no grant at all.
  logic [2:0] prev_gnt = 3'b000;
  always @(negedge clk) begin
    int e;
    if (gnt != 3'b000 && gnt != prev_gnt) begin
      check("dead_cycle", 64'(prev_gnt), 64'd0);
      if (exp_gnt_q.size() == 0) begin
        check("grant_unexpected", 64'(gnt), 64'd0);
      end else begin
        e = exp_gnt_q.pop_front();
        check("grant_order", 64'(gnt), 64'(3'b001 << e));
      end
      $display("grant gnt=%b at %0t", gnt, $time);
    end
    prev_gnt <= gnt;
  end

  task automatic do_reset();
    reset     = 1'b1;
    cyc_drv   = 3'b000;
    stb_drv   = 3'b000;
    ack_auto  = 1'b0;
    ack_force = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Masters issue one single-beat cycle per request, drop cyc for exactly
  // one cycle after each ack and re-request while work remains.
  task automatic run_masters(input int max_cycles);
    bit hold [3];
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    for (int m = 0; m < 3; m++) hold[m] = 1'b0;
    while (!done && n < max_cycles) begin
      @(posedge clk);
      #1;
      for (int m = 0; m < 3; m++) begin
        cyc_drv[m] = (rem[m] > 0) && !hold[m];
        stb_drv[m] = cyc_drv[m];
        hold[m]    = 1'b0;
      end
      @(negedge clk);
      check("ack_route", 64'(ack_vec & ~gnt), 64'd0);
      for (int m = 0; m < 3; m++) begin
        if (ack_vec[m] && rem[m] > 0) begin
          rem[m]--;
          hold[m] = 1'b1;
        end
      end
      done = (rem[0] == 0) && (rem[1] == 0) && (rem[2] == 0) && (gnt == 3'b000);
      n++;
    end
    check("run_done", 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int m = 0; m < 3; m++) begin
      adr_drv[m] = '0;
      dat_drv[m] = '0;
      sel_drv[m] = '0;
    end
    we_drv    = 3'b000;
    cyc_drv   = 3'b000;
    stb_drv   = 3'b000;
    ack_auto  = 1'b0;
    ack_force = 1'b1;   // stray ack while in reset must be discarded
    s_dat_in  = 32'h0;
    adr_drv[0] = 32'h1111_0000;

    // Reset state
    #1 reset = 1'b1;
    #1;
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_cyc", 64'(s_cyc), 64'd0);
    check("rst_stb", 64'(s_stb), 64'd0);
    check("rst_ack", 64'(ack_vec), 64'd0);
    check("rst_err", 64'(err_vec), 64'd0);
    check("rst_mux_owner0", 64'(s_adr), 64'h1111_0000);
    do_reset();
    repeat (2) @(negedge clk);
    check("idle_no_req_gnt", 64'(gnt), 64'd0);

    // Simultaneous requests: m0, m1, m2, m0
    do_reset();
    ack_auto = 1'b1;
    exp_gnt_q.push_back(0);
    exp_gnt_q.push_back(1);
    exp_gnt_q.push_back(2);
    exp_gnt_q.push_back(0);
    rem[0] = 2; rem[1] = 1; rem[2] = 1;
    run_masters(200);

    // Fairness: m0 and m2 alternate
    do_reset();
    ack_auto = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_gnt_q.push_back(0);
      exp_gnt_q.push_back(2);
    end
    rem[0] = 3; rem[1] = 0; rem[2] = 3;
    run_masters(200);

    // Mux correctness: m1 writes while m0/m2 present garbage
    do_reset();
    @(posedge clk); #1;
    adr_drv[0] = 32'hBAD0_0000; dat_drv[0] = 32'h0BAD_0BAD; sel_drv[0] = 4'h3;
    adr_drv[2] = 32'hBAD2_2222; dat_drv[2] = 32'h5555_AAAA; sel_drv[2] = 4'h8;
    adr_drv[1] = 32'h2000_0004; dat_drv[1] = 32'hDEAD_BEEF; sel_drv[1] = 4'hF;
    we_drv  = 3'b010;
    stb_drv = 3'b111;
    cyc_drv = 3'b010;
    s_dat_in = 32'hCAFE_F00D;
    exp_gnt_q.push_back(1);
    @(negedge clk);
    check("grant_latency_gnt", 64'(gnt), 64'd0);
    check("grant_latency_cyc", 64'(s_cyc), 64'd0);
    @(posedge clk); #1 ack_force = 1'b1;
    @(negedge clk);
    check("mux_adr", 64'(s_adr), 64'h2000_0004);
    check("mux_dat", 64'(s_dat_out), 64'hDEAD_BEEF);
    check("mux_sel", 64'(s_sel), 64'hF);
    check("mux_we", 64'(s_we), 64'd1);
    check("mux_cyc", 64'(s_cyc), 64'd1);
    check("mux_stb", 64'(s_stb), 64'd1);
    check("mux_m1_ack", 64'(m1_ack), 64'd1);
    check("mux_m0_ack", 64'(m0_ack), 64'd0);
    check("mux_m2_ack", 64'(m2_ack), 64'd0);
    check("rd_m0_dat", 64'(m0_dat), 64'hCAFE_F00D);
    check("rd_m2_dat", 64'(m2_dat), 64'hCAFE_F00D);
    @(posedge clk); #1;
    ack_force = 1'b0;
    cyc_drv   = 3'b000;
    stb_drv   = 3'b000;
    we_drv    = 3'b000;
    @(negedge clk);
    check("release_gnt_hold", 64'(gnt), 64'b010);
    check("release_cyc", 64'(s_cyc), 64'd0);
    @(negedge clk);
    check("release_gnt_drop", 64'(gnt), 64'd0);

    // Timeout: m2 strobes, slave never acks
    do_reset();
    @(posedge clk); #1;
    cyc_drv = 3'b100;
    stb_drv = 3'b100;
    exp_gnt_q.push_back(2);
    exp_gnt_q.push_back(0);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        cyc_drv[0] = 1'b1;
        stb_drv[0] = 1'b1;
      end
      @(negedge clk);
      check("tmo_pending_err", 64'(m2_err), 64'd0);
      check("tmo_pending_gnt", 64'(gnt), 64'b100);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("tmo_err_m2", 64'(m2_err), 64'd1);
    check("tmo_err_others", 64'({m1_err, m0_err}), 64'd0);
    check("tmo_cyc_low", 64'(s_cyc), 64'd0);
    check("tmo_gnt_low", 64'(gnt), 64'd0);
    @(posedge clk); #1;
    cyc_drv[2] = 1'b0;
    stb_drv[2] = 1'b0;
    @(negedge clk);
    check("tmo_err_once", 64'(m2_err), 64'd0);
    check("tmo_next_gnt", 64'(gnt), 64'b001);
    @(posedge clk); #1 ack_force = 1'b1;
    @(negedge clk);
    check("tmo_next_ack", 64'(m0_ack), 64'd1);
    @(posedge clk); #1;
    ack_force = 1'b0;
    cyc_drv   = 3'b000;
    stb_drv   = 3'b000;
    repeat (2) @(negedge clk);

    // Ack on the deadline cycle wins over the watchdog
    do_reset();
    @(posedge clk); #1;
    cyc_drv = 3'b001;
    stb_drv = 3'b001;
    exp_gnt_q.push_back(0);
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("dl_pending_err", 64'(m0_err), 64'd0);
    end
    @(posedge clk); #1 ack_force = 1'b1;
    @(negedge clk);
    check("dl_ack", 64'(m0_ack), 64'd1);
    check("dl_no_err_same", 64'(m0_err), 64'd0);
    @(posedge clk); #1 ack_force = 1'b0;
    @(negedge clk);
    check("dl_no_err_after", 64'(m0_err), 64'd0);
    check("dl_owner_kept", 64'(gnt), 64'b001);
    check("dl_cyc_kept", 64'(s_cyc), 64'd1);
    for (int k = 6; k <= 8; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("dl_restart_err", 64'(m0_err), 64'd0);
      check("dl_restart_gnt", 64'(gnt), 64'b001);
    end
    @(posedge clk); #1;
    cyc_drv = 3'b000;
    stb_drv = 3'b000;
    @(negedge clk);
    check("dl_restart_abort", 64'(m0_err), 64'd1);
    check("dl_abort_cyc", 64'(s_cyc), 64'd0);
    repeat (2) @(negedge clk);

    // Reset mid-burst while m1 owns the bus
    do_reset();
    @(posedge clk); #1;
    cyc_drv   = 3'b010;
    stb_drv   = 3'b010;
    ack_force = 1'b1;
    exp_gnt_q.push_back(1);
    @(negedge clk);
    check("stray_ack_idle", 64'(ack_vec), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_gnt", 64'(gnt), 64'b010);
    check("mid_ack", 64'(m1_ack), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_cyc", 64'(s_cyc), 64'd0);
    check("async_rst_stb", 64'(s_stb), 64'd0);
    check("async_rst_gnt", 64'(gnt), 64'd0);
    check("async_rst_ack", 64'(ack_vec), 64'd0);
    cyc_drv   = 3'b011;
    stb_drv   = 3'b011;
    ack_force = 1'b0;
    exp_gnt_q.push_back(0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 64'(gnt), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_m0_first", 64'(gnt), 64'b001);
    @(posedge clk); #1;
    cyc_drv = 3'b000;
    stb_drv = 3'b000;
    repeat (3) @(negedge clk);

    check("sb_empty", 64'(exp_gnt_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
